// File: rtl/btn_pkt_pkg.sv
// Shared constants, FSM encoding and packet byte mux for the button event packetizer.
package btn_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         PKT_LEN   = 9;
  localparam int         IDX_W     = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t IDLE       = 2'd0;
  localparam fsm_state_t WAIT_SPACE = 2'd1;
  localparam fsm_state_t SEND       = 2'd2;

  // Byte idx of a packet; index 8 (and anything past it) is the XOR checksum.
  function automatic logic [7:0] pkt_byte(
    input logic [IDX_W-1:0] idx,
    input logic [7:0]       seq,
    input logic [4:0]       state,
    input logic [4:0]       mask,
    input logic [31:0]      ts
  );
    logic [7:0] csum;
    csum = SYNC_BYTE ^ seq ^ {3'b000, state} ^ {3'b000, mask}
         ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0];
    case (idx)
      4'd0:    pkt_byte = SYNC_BYTE;
      4'd1:    pkt_byte = seq;
      4'd2:    pkt_byte = {3'b000, state};
      4'd3:    pkt_byte = {3'b000, mask};
      4'd4:    pkt_byte = ts[31:24];
      4'd5:    pkt_byte = ts[23:16];
      4'd6:    pkt_byte = ts[15:8];
      4'd7:    pkt_byte = ts[7:0];
      default: pkt_byte = csum;
    endcase
  endfunction

endpackage

// File: rtl/btn_event_packetizer_debounce.sv
// One button bit: 2-flop synchronizer followed by a counting debouncer.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic CLK_200M,
  input  logic SYS_RSTn,
  input  logic bt_raw,
  output logic btn_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= bt_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Any cycle of agreement restarts the count, so only a run of
  // DEBOUNCE_CYCLES disagreeing cycles can flip the output.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      cnt       <= '0;
      btn_state <= 1'b0;
    end else if (sync_q2 == btn_state) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt       <= '0;
      btn_state <= ~btn_state;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_event_packetizer.sv
// Debounced button changes become time-stamped 9-byte packets written
// byte-serially into the SiTCP TX FIFO.
module btn_event_packetizer
  import btn_pkt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int FIFO_DEPTH      = 4096,
  parameter int PKT_LEN         = 9
) (
  input  logic        CLK_200M,
  input  logic        SYS_RSTn,
  input  logic        TCP_OPEN_ACK,
  input  logic [4:0]  BT,
  input  logic [11:0] FIFO_DATA_COUNT,
  output logic        FIFO_WR_EN,
  output logic [7:0]  FIFO_DIN,
  output logic [4:0]  BTN_STATE,
  output logic [7:0]  EVT_DROP_CNT,
  output logic        BUSY
);

  localparam logic [11:0] SPACE_MAX = 12'(FIFO_DEPTH - PKT_LEN);

  logic [4:0]       btn_prev;
  logic [31:0]      timestamp;
  logic             evt;
  logic [4:0]       evt_mask;

  logic             pend_valid;
  logic [4:0]       pend_state;
  logic [4:0]       pend_mask;
  logic [31:0]      pend_ts;

  fsm_state_t       fsm_state;
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] byte_idx_nxt;
  logic [7:0]       seq;
  logic [4:0]       pkt_state;
  logic [4:0]       pkt_mask;
  logic [31:0]      pkt_ts;

  logic             has_space;
  logic             consume;

  for (genvar i = 0; i < 5; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .CLK_200M  (CLK_200M),
      .SYS_RSTn  (SYS_RSTn),
      .bt_raw    (BT[i]),
      .btn_state (BTN_STATE[i])
    );
  end

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      btn_prev  <= '0;
      timestamp <= '0;
    end else begin
      btn_prev  <= BTN_STATE;
      timestamp <= timestamp + 32'd1;
    end
  end

  assign evt      = (BTN_STATE != btn_prev);
  assign evt_mask = BTN_STATE ^ btn_prev;

  // Space is only checked before a packet starts; SEND never stalls.
  assign has_space = (FIFO_DATA_COUNT <= SPACE_MAX);
  assign consume   = pend_valid && has_space &&
                     ((fsm_state == IDLE) || (fsm_state == WAIT_SPACE));

  // One-entry pending slot; a slot being drained this cycle can be refilled.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      pend_valid   <= 1'b0;
      pend_state   <= '0;
      pend_mask    <= '0;
      pend_ts      <= '0;
      EVT_DROP_CNT <= '0;
    end else if (!TCP_OPEN_ACK) begin
      pend_valid   <= 1'b0;
      EVT_DROP_CNT <= '0;
    end else if (evt && (!pend_valid || consume)) begin
      pend_valid <= 1'b1;
      pend_state <= BTN_STATE;
      pend_mask  <= evt_mask;
      pend_ts    <= timestamp;
    end else begin
      if (consume) begin
        pend_valid <= 1'b0;
      end
      if (evt && (EVT_DROP_CNT != 8'hFF)) begin
        EVT_DROP_CNT <= EVT_DROP_CNT + 8'd1;
      end
    end
  end

  assign byte_idx_nxt = byte_idx + 4'd1;

  // FIFO write port: FIFO_WR_EN=1 writes FIFO_DIN that cycle with no
  // back-pressure; FIFO_DIN is meaningful only while FIFO_WR_EN is high.
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      fsm_state  <= IDLE;
      byte_idx   <= '0;
      seq        <= '0;
      pkt_state  <= '0;
      pkt_mask   <= '0;
      pkt_ts     <= '0;
      FIFO_WR_EN <= 1'b0;
      FIFO_DIN   <= '0;
    end else if (!TCP_OPEN_ACK) begin
      fsm_state  <= IDLE;
      byte_idx   <= '0;
      seq        <= '0;
      FIFO_WR_EN <= 1'b0;
    end else if (consume) begin
      fsm_state  <= SEND;
      byte_idx   <= '0;
      pkt_state  <= pend_state;
      pkt_mask   <= pend_mask;
      pkt_ts     <= pend_ts;
      FIFO_WR_EN <= 1'b1;
      FIFO_DIN   <= SYNC_BYTE;
    end else begin
      case (fsm_state)
        IDLE: begin
          if (pend_valid) begin
            fsm_state <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          fsm_state <= WAIT_SPACE;
        end
        SEND: begin
          if (byte_idx == IDX_LAST) begin
            fsm_state  <= IDLE;
            FIFO_WR_EN <= 1'b0;
            seq        <= seq + 8'd1;
          end else begin
            byte_idx <= byte_idx_nxt;
            FIFO_DIN <= pkt_byte(byte_idx_nxt, seq, pkt_state, pkt_mask, pkt_ts);
          end
        end
        default: begin
          fsm_state  <= IDLE;
          FIFO_WR_EN <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = (fsm_state == WAIT_SPACE) || (fsm_state == SEND);

endmodule
